branch_predictor: RTL and testbench

//  Parametrised branch target buffer (BTB) with 2-bit saturating direction counters for the pipelined MIPS core.
//  IF-stage lookup: predicts next PC for the fetch PC.
//  ID-stage update: trains the table when a branch/jump resolves, flags mispredicts and supplies the corrected PC.

---
 rtl/bp_types_pkg.sv | 40 ++++
 rtl/bp_stat_counter.sv | 24 ++
 rtl/branch_predictor.sv | 100 ++++++++++
 tb/tb_branch_predictor.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_types_pkg.sv
// Shared types, counter encodings and helpers for the branch predictor.
package bp_types_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef enum logic {
    BP_BIMODAL = 1'b0,
    BP_GSHARE  = 1'b1
  } bp_mode_t;

  // The tag is held at full PC width (pc >> (IDX_W+2)); high bits stay zero.
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
    logic [1:0]  ctr;
    logic        is_jump;
  } bp_entry_t;

  localparam bp_entry_t ENTRY_RST = '{
    valid:   1'b0,
    tag:     32'h0,
    target:  32'h0,
    ctr:     CTR_WNT,
    is_jump: 1'b0
  };

  function automatic logic [31:0] tag_of(input logic [31:0] pc, input int idx_w);
    return pc >> (idx_w + 2);
  endfunction

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bp_stat_counter.sv
// Saturating event counter; holds at all-ones and while i_freeze is high.
module bp_stat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  input  logic         i_freeze,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_inc && !i_freeze && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/branch_predictor.sv
// Flop-array BTB with 2-bit direction counters, bimodal or gshare indexing.
// Lookup is combinational from registered state; training lands on the next edge.
module branch_predictor
  import bp_types_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int MODE    = 0,
  parameter int GHR_W   = 4,
  parameter int STAT_W  = 32,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              clr,
  input  logic              halt,
  input  logic [31:0]       if_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  output logic [IDX_W-1:0]  pred_idx,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_is_branch,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              upd_pred_taken,
  input  logic [31:0]       upd_pred_target,
  output logic              mispredict,
  output logic [31:0]       correct_pc,
  output logic [STAT_W-1:0] stat_updates,
  output logic [STAT_W-1:0] stat_mispred
);

  localparam bit GSHARE = (MODE == int'(BP_GSHARE));

  bp_entry_t        r_table [ENTRIES];
  logic [GHR_W-1:0] r_ghr;
  logic [IDX_W-1:0] w_idx;
  logic             w_upd_hit;

  always_comb begin
    w_idx = if_pc[IDX_W+1:2];
    if (GSHARE) w_idx = w_idx ^ IDX_W'(r_ghr);
  end

  assign pred_idx    = w_idx;
  assign pred_hit    = r_table[w_idx].valid && (r_table[w_idx].tag == tag_of(if_pc, IDX_W));
  assign pred_taken  = pred_hit && (r_table[w_idx].is_jump || r_table[w_idx].ctr[1]);
  assign pred_target = pred_taken ? r_table[w_idx].target : if_pc + 32'd4;

  assign w_upd_hit  = r_table[upd_idx].valid && (r_table[upd_idx].tag == tag_of(upd_pc, IDX_W));
  assign mispredict = upd_valid &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && (upd_target != upd_pred_target)));
  assign correct_pc = upd_taken ? upd_target : upd_pc + 32'd4;

  // clr beats a same-cycle update; not-taken misses never allocate.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) r_table[i] <= ENTRY_RST;
      r_ghr <= '0;
    end else if (clr) begin
      for (int i = 0; i < ENTRIES; i++) r_table[i] <= ENTRY_RST;
      r_ghr <= '0;
    end else if (upd_valid) begin
      if (w_upd_hit) begin
        r_table[upd_idx].ctr     <= ctr_next(r_table[upd_idx].ctr, upd_taken);
        r_table[upd_idx].is_jump <= !upd_is_branch;
        if (upd_taken) r_table[upd_idx].target <= upd_target;
      end else if (upd_taken) begin
        r_table[upd_idx] <= '{
          valid:   1'b1,
          tag:     tag_of(upd_pc, IDX_W),
          target:  upd_target,
          ctr:     CTR_WT,
          is_jump: !upd_is_branch
        };
      end
      if (GSHARE && upd_is_branch) r_ghr <= (r_ghr << 1) | GHR_W'(upd_taken);
    end
  end

  bp_stat_counter #(.W(STAT_W)) u_stat_updates (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_inc    (upd_valid),
    .i_freeze (halt),
    .o_count  (stat_updates)
  );

  bp_stat_counter #(.W(STAT_W)) u_stat_mispred (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_inc    (mispredict),
    .i_freeze (halt),
    .o_count  (stat_mispred)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: bimodal/32-bit stats, bimodal/4-bit stats and gshare instances on shared stimulus.
module tb_branch_predictor;
  localparam int IDX_W = 4;

  logic CLK = 1'b0, RST = 1'b1, clr = 1'b0, halt = 1'b0;
  logic [31:0] if_pc = '0, upd_pc = '0, upd_target = '0, upd_pred_target = '0;
  logic [IDX_W-1:0] upd_idx = '0;
  logic upd_valid = 1'b0, upd_is_branch = 1'b0, upd_taken = 1'b0, upd_pred_taken = 1'b0;

  logic bm_hit, bm_taken, bm_mis, sat_hit, sat_taken, sat_mis, gs_hit, gs_taken, gs_mis;
  logic [31:0] bm_target, bm_cpc, sat_target, sat_cpc, gs_target, gs_cpc;
  logic [IDX_W-1:0] bm_idx, sat_idx, gs_idx;
  logic [31:0] bm_su, bm_sm, gs_su, gs_sm;
  logic [3:0] sat_su, sat_sm;

  branch_predictor #(.ENTRIES(16), .MODE(0), .GHR_W(4), .STAT_W(32)) u_bm (
    .CLK(CLK), .RST(RST), .clr(clr), .halt(halt), .if_pc(if_pc),
    .pred_hit(bm_hit), .pred_taken(bm_taken), .pred_target(bm_target), .pred_idx(bm_idx),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_idx(upd_idx), .upd_is_branch(upd_is_branch),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .mispredict(bm_mis), .correct_pc(bm_cpc),
    .stat_updates(bm_su), .stat_mispred(bm_sm));

  branch_predictor #(.ENTRIES(16), .MODE(0), .GHR_W(4), .STAT_W(4)) u_sat (
    .CLK(CLK), .RST(RST), .clr(clr), .halt(halt), .if_pc(if_pc),
    .pred_hit(sat_hit), .pred_taken(sat_taken), .pred_target(sat_target), .pred_idx(sat_idx),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_idx(upd_idx), .upd_is_branch(upd_is_branch),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .mispredict(sat_mis), .correct_pc(sat_cpc),
    .stat_updates(sat_su), .stat_mispred(sat_sm));

  branch_predictor #(.ENTRIES(16), .MODE(1), .GHR_W(4), .STAT_W(32)) u_gs (
    .CLK(CLK), .RST(RST), .clr(clr), .halt(halt), .if_pc(if_pc),
    .pred_hit(gs_hit), .pred_taken(gs_taken), .pred_target(gs_target), .pred_idx(gs_idx),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_idx(upd_idx), .upd_is_branch(upd_is_branch),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .mispredict(gs_mis), .correct_pc(gs_cpc),
    .stat_updates(gs_su), .stat_mispred(gs_sm));

  always #5 CLK = ~CLK;

  typedef struct packed {logic hit; logic tk; logic [31:0] tgt;} lk_t;
  typedef struct packed {logic mis; logic [31:0] cpc;} up_t;
  typedef struct {
    logic c, h, uv, br, tk, ptk, ehit, etk, emis;
    logic [31:0] upc, tgt, ptgt, ipc, etgt, ecpc;
  } step_t;

  lk_t q_lk[$];
  up_t q_up[$];
  int n_tests = 0, n_fail = 0;
  int m_upd = 0, m_mis = 0;

  function automatic step_t mk(logic uv, logic [31:0] upc, logic br, logic tk, logic [31:0] tgt,
                               logic ptk, logic [31:0] ptgt, logic [31:0] ipc,
                               logic ehit, logic etk, logic [31:0] etgt, logic emis, logic [31:0] ecpc);
    step_t s;
    s.c = 1'b0; s.h = 1'b0; s.uv = uv; s.upc = upc; s.br = br; s.tk = tk; s.tgt = tgt;
    s.ptk = ptk; s.ptgt = ptgt; s.ipc = ipc; s.ehit = ehit; s.etk = etk; s.etgt = etgt;
    s.emis = emis; s.ecpc = ecpc;
    return s;
  endfunction

  function automatic step_t idle(logic [31:0] ipc, logic ehit, logic etk, logic [31:0] etgt);
    return mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, ipc, ehit, etk, etgt, 1'b0, 32'h0);
  endfunction

  // Drives one cycle of stimulus and records what the outputs must show for it.
  task automatic apply(input step_t s);
    clr = s.c; halt = s.h; upd_valid = s.uv; upd_pc = s.upc; upd_idx = s.upc[IDX_W+1:2];
    upd_is_branch = s.br; upd_taken = s.tk; upd_target = s.tgt;
    upd_pred_taken = s.ptk; upd_pred_target = s.ptgt; if_pc = s.ipc;
    q_lk.push_back('{hit: s.ehit, tk: s.etk, tgt: s.etgt});
    q_up.push_back('{mis: s.emis, cpc: s.ecpc});
    if (s.uv && !s.h) begin
      m_upd++;
      if (s.emis) m_mis++;
    end
  endtask

  task automatic test_reset();
    lk_t e_lk; up_t e_up;
    apply(mk(1, 'h100, 1, 1, 'h80, 0, 'h104, 'h40, 0, 0, 'h44, 1, 'h80)); #2;
    e_lk = q_lk.pop_front(); e_up = q_up.pop_front();
    n_tests++;
    if ({bm_hit, bm_taken, bm_target} !== e_lk || bm_su !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_initial: got hit=%0b taken=%0b target=%h upd=%0d, want %0b/%0b/%h/0",
               bm_hit, bm_taken, bm_target, bm_su, e_lk.hit, e_lk.tk, e_lk.tgt);
    end
    @(posedge CLK); #1;
    apply(mk(1, 'h104, 0, 1, 'h500, 0, 'h108, 'h100, 1, 1, 'h80, 1, 'h500)); #2;
    e_lk = q_lk.pop_front();
    n_tests++;
    if ({bm_hit, bm_taken, bm_target} !== e_lk || bm_su !== 32'd1 || bm_sm !== 32'd1) begin
      n_fail++;
      $display("FAIL reset_prerun: got hit=%0b taken=%0b target=%h upd=%0d mis=%0d, want %0b/%0b/%h/1/1",
               bm_hit, bm_taken, bm_target, bm_su, bm_sm, e_lk.hit, e_lk.tk, e_lk.tgt);
    end
    if_pc = 'h40; RST = 1'b1; #1;
    n_tests++;
    if ({bm_hit, bm_taken, bm_target} !== {2'b00, 32'h44} ||
        bm_su !== 32'd0 || bm_sm !== 32'd0 || sat_su !== 4'd0 || gs_su !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_async: got hit=%0b taken=%0b target=%h upd=%0d mis=%0d, want 0/0/00000044/0/0",
               bm_hit, bm_taken, bm_target, bm_su, bm_sm);
    end
    @(posedge CLK); #1;
    RST = 1'b0; upd_valid = 1'b0; m_upd = 0; m_mis = 0; q_lk.delete(); q_up.delete();
    for (int i = 0; i < 2; i++) begin
      apply(i == 0 ? idle('h104, 0, 0, 'h108) : idle('h100, 0, 0, 'h104)); #2;
      e_lk = q_lk.pop_front(); e_up = q_up.pop_front();
      n_tests++;
      if ({bm_hit, bm_taken, bm_target} !== e_lk || bm_mis !== e_up.mis) begin
        n_fail++;
        $display("FAIL reset_entries[%0d]: got hit=%0b taken=%0b target=%h mis=%0b, want %0b/%0b/%h/0",
                 i, bm_hit, bm_taken, bm_target, bm_mis, e_lk.hit, e_lk.tk, e_lk.tgt);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_cold_miss();
    step_t st[2]; lk_t e_lk; up_t e_up;
    st[0] = mk(1, 'h100, 1, 1, 'h80, 0, 'h104, 'h100, 0, 0, 'h104, 1, 'h80);
    st[1] = idle('h100, 1, 1, 'h80);
    for (int i = 0; i < 2; i++) begin
      apply(st[i]); #2;
      e_lk = q_lk.pop_front(); e_up = q_up.pop_front();
      n_tests++;
      if ({bm_hit, bm_taken, bm_target} !== e_lk) begin
        n_fail++;
        $display("FAIL cold_lookup[%0d]: got hit=%0b taken=%0b target=%h, want %0b/%0b/%h",
                 i, bm_hit, bm_taken, bm_target, e_lk.hit, e_lk.tk, e_lk.tgt);
      end
      n_tests++;
      if (bm_mis !== e_up.mis || (st[i].uv && bm_cpc !== e_up.cpc)) begin
        n_fail++;
        $display("FAIL cold_update[%0d]: got mispredict=%0b correct_pc=%h, want %0b/%h",
                 i, bm_mis, bm_cpc, e_up.mis, e_up.cpc);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_saturation();
    step_t st[6]; lk_t e_lk; up_t e_up;
    for (int i = 0; i < 3; i++)
      st[i] = mk(1, 'h100, 1, 0, 'h80, 1, 'h80, 'h100, 1, (i == 0), (i == 0) ? 'h80 : 'h104, 1, 'h104);
    st[3] = mk(1, 'h100, 1, 1, 'h80, 0, 'h104, 'h100, 1, 0, 'h104, 1, 'h80);
    st[4] = mk(1, 'h100, 1, 1, 'h80, 0, 'h104, 'h100, 1, 0, 'h104, 1, 'h80);
    st[5] = idle('h100, 1, 1, 'h80);
    for (int i = 0; i < 6; i++) begin
      apply(st[i]); #2;
      e_lk = q_lk.pop_front(); e_up = q_up.pop_front();
      n_tests++;
      if ({bm_hit, bm_taken, bm_target} !== e_lk) begin
        n_fail++;
        $display("FAIL sat_lookup[%0d]: got hit=%0b taken=%0b target=%h, want %0b/%0b/%h",
                 i, bm_hit, bm_taken, bm_target, e_lk.hit, e_lk.tk, e_lk.tgt);
      end
      n_tests++;
      if (bm_mis !== e_up.mis || (st[i].uv && bm_cpc !== e_up.cpc)) begin
        n_fail++;
        $display("FAIL sat_update[%0d]: got mispredict=%0b correct_pc=%h, want %0b/%h",
                 i, bm_mis, bm_cpc, e_up.mis, e_up.cpc);
      end
      @(posedge CLK); #1;
    end
    n_tests++;
    if (bm_su !== 32'(m_upd) || bm_sm !== 32'(m_mis)) begin
      n_fail++;
      $display("FAIL sat_stats: got updates=%0d mispred=%0d, want %0d/%0d", bm_su, bm_sm, m_upd, m_mis);
    end
  endtask

  task automatic test_aliasing();
    step_t st[4]; lk_t e_lk; up_t e_up;
    st[0] = idle('h140, 0, 0, 'h144);
    st[1] = mk(1, 'h140, 1, 1, 'h200, 0, 'h144, 'h100, 1, 1, 'h80, 1, 'h200);
    st[2] = idle('h140, 1, 1, 'h200);
    st[3] = idle('h100, 0, 0, 'h104);
    for (int i = 0; i < 4; i++) begin
      apply(st[i]); #2;
      e_lk = q_lk.pop_front(); e_up = q_up.pop_front();
      n_tests++;
      if ({bm_hit, bm_taken, bm_target} !== e_lk || bm_idx !== 4'd0) begin
        n_fail++;
        $display("FAIL alias_lookup[%0d]: got hit=%0b taken=%0b target=%h idx=%0d, want %0b/%0b/%h/0",
                 i, bm_hit, bm_taken, bm_target, bm_idx, e_lk.hit, e_lk.tk, e_lk.tgt);
      end
      n_tests++;
      if (bm_mis !== e_up.mis || (st[i].uv && bm_cpc !== e_up.cpc)) begin
        n_fail++;
        $display("FAIL alias_update[%0d]: got mispredict=%0b correct_pc=%h, want %0b/%h",
                 i, bm_mis, bm_cpc, e_up.mis, e_up.cpc);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_same_cycle();
    step_t st[3]; lk_t e_lk; up_t e_up;
    st[0] = mk(1, 'h140, 1, 0, 'h200, 1, 'h200, 'h140, 1, 1, 'h200, 1, 'h144);
    st[1] = mk(1, 'h104, 0, 1, 'h500, 0, 'h108, 'h140, 1, 0, 'h144, 1, 'h500);
    st[2] = idle('h104, 1, 1, 'h500);
    for (int i = 0; i < 3; i++) begin
      apply(st[i]); #2;
      e_lk = q_lk.pop_front(); e_up = q_up.pop_front();
      n_tests++;
      if ({bm_hit, bm_taken, bm_target} !== e_lk) begin
        n_fail++;
        $display("FAIL same_cycle_lookup[%0d]: got hit=%0b taken=%0b target=%h, want %0b/%0b/%h",
                 i, bm_hit, bm_taken, bm_target, e_lk.hit, e_lk.tk, e_lk.tgt);
      end
      n_tests++;
      if (bm_mis !== e_up.mis || (st[i].uv && bm_cpc !== e_up.cpc)) begin
        n_fail++;
        $display("FAIL same_cycle_update[%0d]: got mispredict=%0b correct_pc=%h, want %0b/%h",
                 i, bm_mis, bm_cpc, e_up.mis, e_up.cpc);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_clr();
    step_t st[3]; lk_t e_lk; up_t e_up;
    st[0] = mk(1, 'h140, 1, 1, 'h300, 0, 'h144, 'h104, 1, 1, 'h500, 1, 'h300);
    st[0].c = 1'b1;
    st[1] = idle('h140, 0, 0, 'h144);
    st[2] = idle('h104, 0, 0, 'h108);
    for (int i = 0; i < 3; i++) begin
      apply(st[i]); #2;
      e_lk = q_lk.pop_front(); e_up = q_up.pop_front();
      n_tests++;
      if ({bm_hit, bm_taken, bm_target} !== e_lk || bm_mis !== e_up.mis) begin
        n_fail++;
        $display("FAIL clr_lookup[%0d]: got hit=%0b taken=%0b target=%h mis=%0b, want %0b/%0b/%h/%0b",
                 i, bm_hit, bm_taken, bm_target, bm_mis, e_lk.hit, e_lk.tk, e_lk.tgt, e_up.mis);
      end
      @(posedge CLK); #1;
    end
    n_tests++;
    if (bm_su !== 32'(m_upd) || bm_sm !== 32'(m_mis)) begin
      n_fail++;
      $display("FAIL clr_stats: got updates=%0d mispred=%0d, want %0d/%0d", bm_su, bm_sm, m_upd, m_mis);
    end
  endtask

  task automatic test_stats();
    step_t st[24]; lk_t e_lk; up_t e_up; logic [3:0] e_su4, e_sm4;
    for (int i = 0; i < 20; i++) st[i] = mk(1, 'h800, 1, 0, 'h10, 0, 'h10, 'h40, 0, 0, 'h44, 0, 'h804);
    for (int i = 20; i < 23; i++) begin
      st[i] = mk(1, 'h900, 1, 1, 'h10, 0, 'h904, 'h40, 0, 0, 'h44, 1, 'h10);
      st[i].h = 1'b1;
    end
    st[23] = idle('h40, 0, 0, 'h44);
    for (int i = 0; i < 24; i++) begin
      apply(st[i]); #2;
      e_lk = q_lk.pop_front(); e_up = q_up.pop_front();
      n_tests++;
      if (bm_mis !== e_up.mis || (st[i].uv && bm_cpc !== e_up.cpc) || bm_hit !== e_lk.hit) begin
        n_fail++;
        $display("FAIL stats_step[%0d]: got mispredict=%0b correct_pc=%h hit=%0b, want %0b/%h/%0b",
                 i, bm_mis, bm_cpc, bm_hit, e_up.mis, e_up.cpc, e_lk.hit);
      end
      @(posedge CLK); #1;
    end
    e_su4 = (m_upd > 15) ? 4'hF : 4'(m_upd);
    e_sm4 = (m_mis > 15) ? 4'hF : 4'(m_mis);
    n_tests++;
    if (sat_su !== e_su4 || sat_sm !== e_sm4) begin
      n_fail++;
      $display("FAIL stats_saturate: got updates=%0d mispred=%0d, want %0d/%0d", sat_su, sat_sm, e_su4, e_sm4);
    end
    n_tests++;
    if (bm_su !== 32'(m_upd) || bm_sm !== 32'(m_mis)) begin
      n_fail++;
      $display("FAIL stats_halt: got updates=%0d mispred=%0d, want %0d/%0d", bm_su, bm_sm, m_upd, m_mis);
    end
  endtask

  task automatic test_gshare();
    step_t st[8]; lk_t e_lk; up_t e_up; logic [IDX_W-1:0] e_idx [8];
    st[0] = idle('h100, 0, 0, 'h104);
    st[0].c = 1'b1;
    st[1] = mk(1, 'h100, 1, 1, 'h80, 1, 'h80, 'h100, 0, 0, 'h104, 0, 'h80);
    st[2] = mk(1, 'h100, 1, 1, 'h80, 1, 'h80, 'h100, 1, 1, 'h80, 0, 'h80);
    st[3] = mk(1, 'h100, 1, 0, 'h80, 0, 'h80, 'h100, 1, 1, 'h80, 0, 'h104);
    st[4] = mk(1, 'h104, 0, 1, 'h500, 1, 'h500, 'h100, 1, 1, 'h80, 0, 'h500);
    st[5] = idle('h100, 1, 1, 'h80);
    st[6] = mk(1, 'h104, 0, 1, 'h600, 1, 'h500, 'h100, 1, 1, 'h80, 1, 'h600);
    st[7] = idle('h100, 1, 1, 'h80);
    e_idx[0] = 4'd0; e_idx[1] = 4'd0; e_idx[2] = 4'd1; e_idx[3] = 4'd3;
    e_idx[4] = 4'd6; e_idx[5] = 4'd6; e_idx[6] = 4'd6; e_idx[7] = 4'd6;
    for (int i = 0; i < 8; i++) begin
      apply(st[i]); #2;
      e_lk = q_lk.pop_front(); e_up = q_up.pop_front();
      n_tests++;
      if ({bm_hit, bm_taken, bm_target} !== e_lk || bm_idx !== 4'd0) begin
        n_fail++;
        $display("FAIL gshare_bimodal_lookup[%0d]: got hit=%0b taken=%0b target=%h idx=%0d, want %0b/%0b/%h/0",
                 i, bm_hit, bm_taken, bm_target, bm_idx, e_lk.hit, e_lk.tk, e_lk.tgt);
      end
      n_tests++;
      if (gs_mis !== e_up.mis || (st[i].uv && gs_cpc !== e_up.cpc)) begin
        n_fail++;
        $display("FAIL gshare_update[%0d]: got mispredict=%0b correct_pc=%h, want %0b/%h",
                 i, gs_mis, gs_cpc, e_up.mis, e_up.cpc);
      end
      if (i > 0) begin
        n_tests++;
        if (gs_idx !== e_idx[i]) begin
          n_fail++;
          $display("FAIL gshare_idx[%0d]: got %0d, want %0d", i, gs_idx, e_idx[i]);
        end
      end
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    test_reset();
    test_cold_miss();
    test_saturation();
    test_aliasing();
    test_same_cycle();
    test_clr();
    test_stats();
    test_gshare();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
